serial_add_controller: RTL and testbench



---
 rtl/serial_add_controller_if.sv | 41 ++++
 rtl/serial_add_controller.sv | 128 ++++++++++++
 tb/tb_serial_add_controller.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_add_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_controller_if
// Purpose  : Command / result handshake bundle for serial_add_controller.
//            The requester/consumer side uses the master modport, the
//            controller uses the slave modport.
// Signals  : start_valid/start_ready  command handshake
//            op_a, op_b, sub           command payload (W = 4*NIBBLES bits)
//            res_valid/res_ready       result handshake
//            result, carryout, overflow result payload
//            busy                      controller in RUN or DONE
// Revision : 1.0 - initial release
// ============================================================================
interface serial_add_controller_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] result;
  logic         carryout;
  logic         overflow;
  logic         busy;

  modport master (
    output start_valid, op_a, op_b, sub, res_ready,
    input  start_ready, res_valid, result, carryout, overflow, busy
  );

  modport slave (
    input  start_valid, op_a, op_b, sub, res_ready,
    output start_ready, res_valid, result, carryout, overflow, busy
  );
endinterface
`default_nettype wire

// File: rtl/serial_add_controller.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_controller
// Purpose  : W-bit two's-complement add/subtract computed by one 4-bit adder
//            slice stepped across the operands, LSB nibble first, one nibble
//            per clock, carry chained between passes.
// Ports    : clk    - clock, rising edge
//            rst_n  - asynchronous active-low reset
//            bus    - serial_add_controller_if.slave (command + result)
// Revision : 1.0 - initial release
// ============================================================================
module serial_add_controller #(
  parameter int NIBBLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  serial_add_controller_if.slave  bus
);

  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    result_q, result_d;
  logic            carry_q, carry_d;
  logic            carryout_q, carryout_d;
  logic            overflow_q, overflow_d;
  logic [IDXW-1:0] idx_q, idx_d;

  // Shared 4-bit adder slice working on the nibble selected by idx_q
  logic [3:0] a_nib;
  logic [3:0] b_nib;
  logic [4:0] slice_sum;
  logic       slice_cout;
  logic       slice_c3;

  assign a_nib      = a_q[{idx_q, 2'b00} +: 4];
  assign b_nib      = b_q[{idx_q, 2'b00} +: 4];
  assign slice_sum  = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
  assign slice_cout = slice_sum[4];
  // Carry into the slice MSB recovered from the sum bit: s3 = a3 ^ b3 ^ c3
  assign slice_c3   = a_nib[3] ^ b_nib[3] ^ slice_sum[3];

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    carry_d    = carry_q;
    carryout_d = carryout_q;
    overflow_d = overflow_q;
    idx_d      = idx_q;

    case (state_q)
      IDLE: begin
        if (bus.start_valid) begin
          // Subtraction is A + ~B + 1: invert B and seed the carry with 1
          a_d     = bus.op_a;
          b_d     = bus.sub ? ~bus.op_b : bus.op_b;
          carry_d = bus.sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        result_d[{idx_q, 2'b00} +: 4] = slice_sum[3:0];
        carry_d = slice_cout;
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          carryout_d = slice_cout;
          overflow_d = slice_c3 ^ slice_cout;
          state_d    = DONE;
        end
      end

      DONE: begin
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      carryout_q <= 1'b0;
      overflow_q <= 1'b0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      carryout_q <= carryout_d;
      overflow_q <= overflow_d;
      idx_q      <= idx_d;
    end
  end

  assign bus.start_ready = (state_q == IDLE);
  assign bus.res_valid   = (state_q == DONE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.result      = result_q;
  assign bus.carryout    = carryout_q;
  assign bus.overflow    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_add_controller
// Purpose  : Directed self-checking bench for serial_add_controller with a
//            NIBBLES=4 instance and a NIBBLES=1 instance on a shared clock.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_add_controller;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  serial_add_controller_if #(.NIBBLES(4)) b4 ();
  serial_add_controller_if #(.NIBBLES(1)) b1 ();

  serial_add_controller #(.NIBBLES(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b4.slave)
  );

  serial_add_controller #(.NIBBLES(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full transaction on the 4-nibble instance; res_ready held low until
  // res_valid is seen so the latency can be measured.
  task automatic run4(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic s, input logic [15:0] er, input logic ec, input logic ev);
    int cyc;
    @(negedge clk);
    b4.start_valid = 1'b1;
    b4.op_a        = a;
    b4.op_b        = b;
    b4.sub         = s;
    b4.res_ready   = 1'b0;
    @(negedge clk);
    cyc = 1;
    b4.start_valid = 1'b0;
    check({tag, "_run_busy_rdy"}, {b4.busy, b4.start_ready}, 2'b10);
    while (!b4.res_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    // accept edge plus four RUN edges
    check({tag, "_latency"}, cyc, 5);
    check({tag, "_result"}, b4.result, er);
    check({tag, "_carry_ovf"}, {b4.carryout, b4.overflow}, {ec, ev});
    check({tag, "_done_rdy"}, b4.start_ready, 1'b0);
    b4.res_ready = 1'b1;
    @(negedge clk);
    b4.res_ready = 1'b0;
    check({tag, "_idle_flags"}, {b4.res_valid, b4.start_ready, b4.busy}, 3'b010);
    check({tag, "_idle_hold"}, b4.result, er);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    b4.start_valid = 1'b1;
    b4.op_a        = 16'hA5C3;
    b4.op_b        = 16'h3C5A;
    b4.sub         = 1'b1;
    b4.res_ready   = 1'b1;
    b1.start_valid = 1'b1;
    b1.op_a        = 4'h9;
    b1.op_b        = 4'h7;
    b1.sub         = 1'b0;
    b1.res_ready   = 1'b1;

    // Reset held with active inputs
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b4.op_a = 16'($urandom);
      b4.op_b = 16'($urandom);
    end
    check("rst4_flags", {b4.start_ready, b4.res_valid, b4.busy}, 3'b100);
    check("rst4_result", b4.result, 16'h0000);
    check("rst4_carry_ovf", {b4.carryout, b4.overflow}, 2'b00);
    check("rst1_all", {b1.start_ready, b1.res_valid, b1.busy, b1.carryout, b1.overflow, b1.result},
          {5'b10000, 4'h0});

    b4.start_valid = 1'b0;
    b1.start_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Add / subtract vectors
    run4("add_7fff_1", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run4("add_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run4("sub_3_5",    16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run4("sub_8000_1", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Backpressure: 0x0010 + 0x0020 = 0x0030 held in DONE
    @(negedge clk);
    b4.start_valid = 1'b1;
    b4.op_a = 16'h0010;
    b4.op_b = 16'h0020;
    b4.sub  = 1'b0;
    b4.res_ready = 1'b0;
    @(negedge clk);
    b4.start_valid = 1'b0;
    begin
      int cyc;
      cyc = 1;
      while (!b4.res_valid && cyc < 40) begin
        @(negedge clk);
        cyc++;
      end
      check("bp_latency", cyc, 5);
    end
    for (int i = 0; i < 10; i++) begin
      b4.start_valid = 1'b1;
      b4.op_a = 16'(16'h1111 * (i + 1));
      @(negedge clk);
      check("bp_hold", {b4.res_valid, b4.start_ready, b4.busy, b4.result}, {3'b101, 16'h0030});
    end
    b4.start_valid = 1'b0;
    b4.res_ready   = 1'b1;
    @(negedge clk);
    b4.res_ready   = 1'b0;
    check("bp_release", {b4.res_valid, b4.start_ready, b4.busy}, 3'b010);
    run4("bp_next", 16'h1000, 16'h2345, 1'b0, 16'h3345, 1'b0, 1'b0);

    // Reset in the middle of RUN: 0xFFFF + 0x1111 has a non-zero partial sum
    @(negedge clk);
    b4.start_valid = 1'b1;
    b4.op_a = 16'hFFFF;
    b4.op_b = 16'h1111;
    b4.sub  = 1'b0;
    @(negedge clk);
    b4.start_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_flags", {b4.start_ready, b4.res_valid, b4.busy}, 3'b100);
    check("midrst_result", b4.result, 16'h0000);
    check("midrst_carry_ovf", {b4.carryout, b4.overflow}, 2'b00);
    @(negedge clk);
    @(negedge clk);
    check("midrst_no_valid", b4.res_valid, 1'b0);
    rst_n = 1'b1;
    run4("after_rst", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);

    // NIBBLES=1 exhaustive add sweep against a 4-bit reference
    b1.res_ready = 1'b1;
    b1.sub       = 1'b0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        logic [3:0] ra, rb, rs;
        logic [4:0] full;
        logic       rv;
        ra   = 4'(a);
        rb   = 4'(b);
        full = 5'(a + b);
        rs   = full[3:0];
        rv   = (ra[3] == rb[3]) && (rs[3] != ra[3]);
        @(negedge clk);
        b1.start_valid = 1'b1;
        b1.op_a = ra;
        b1.op_b = rb;
        @(negedge clk);
        b1.start_valid = 1'b0;
        @(negedge clk);
        check($sformatf("n1_add_%0h_%0h", a, b),
              {b1.res_valid, b1.carryout, b1.overflow, b1.result},
              {1'b1, full[4], rv, rs});
      end
    end
    @(negedge clk);
    check("n1_idle_after", {b1.res_valid, b1.start_ready}, 2'b01);

    // NIBBLES=1 subtract: 0011 - 0101 = 1110, borrow (c=0), no overflow
    b1.res_ready = 1'b1;
    b1.start_valid = 1'b1;
    b1.op_a = 4'h3;
    b1.op_b = 4'h5;
    b1.sub  = 1'b1;
    @(negedge clk);
    b1.start_valid = 1'b0;
    @(negedge clk);
    check("n1_sub_3_5", {b1.res_valid, b1.carryout, b1.overflow, b1.result}, {3'b100, 4'hE});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so the bench always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
